mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 37 +++
 rtl/mem_arbiter_if.sv | 30 +++
 rtl/mem_arbiter_rr.sv | 29 ++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the memory-port arbiter: FSM states, widths,
// and the line/lane address arithmetic used by the read-modify-write path.
package mem_arbiter_pkg;

  localparam int LINE_W   = 128;
  localparam int WORD_W   = 32;
  localparam int LANE_LSB = 2;

  typedef enum logic [2:0] {IDLE, RD, MERGE, WR, DONE} arb_state_t;

  // Fields captured at grant; later req_* changes never reach the FSM.
  typedef struct packed {
    logic              we;
    logic [1:0]        lane;
    logic [WORD_W-1:0] wdat;
  } req_t;

  function automatic logic [WORD_W-1:0] line_addr(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:4], 4'b0000};
  endfunction

  function automatic logic [1:0] lane_of(input logic [WORD_W-1:0] addr);
    return addr[LANE_LSB +: 2];
  endfunction

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [WORD_W-1:0] word,
                                                   input logic [1:0]        lane);
    logic [LINE_W-1:0] m;
    m = line;
    for (int l = 0; l < 4; l++) begin
      if (lane == 2'(l)) m[l*WORD_W +: WORD_W] = word;
    end
    return m;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter; the arbiter is the
// slave of its requesters, the environment (requesters + memory) is the master.
interface mem_arbiter_if #(parameter int N_REQ = 4);
  import mem_arbiter_pkg::*;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*WORD_W-1:0] req_addr;
  logic [N_REQ*WORD_W-1:0] req_wdat;
  logic [N_REQ-1:0]        rsp_done;
  logic [LINE_W-1:0]       rsp_rdat;
  logic                    busy;
  logic [WORD_W-1:0]       mem_addr_sel;
  logic                    mem_en;
  logic                    mem_re;
  logic                    mem_we;
  logic [LINE_W-1:0]       mem_wdat;
  logic [LINE_W-1:0]       mem_rdat;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdat, mem_rdat,
    output rsp_done, rsp_rdat, busy, mem_addr_sel, mem_en, mem_re, mem_we, mem_wdat
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdat, mem_rdat,
    input  rsp_done, rsp_rdat, busy, mem_addr_sel, mem_en, mem_re, mem_we, mem_wdat
  );

endinterface

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N. The pointer register lives in the arbiter FSM.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);
  localparam int SW = IDX_W + 1;

  logic [N-1:0] rot;
  logic [SW-1:0] sum;

  // NOTE: every variable written here gets a default before any branch, so no latch is inferred.
  always_comb begin
    rot = N'({req, req} >> ptr);
    any = |rot;
    sum = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) sum = SW'(i) + SW'(ptr);
    end
    if (sum >= SW'(N)) sum = sum - SW'(N);
    gnt_idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between N_REQ requesters: full-line reads or a
// read-modify-write of one word, one transaction at a time, round-robin.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 2
) (
  input  logic          mclk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);
  localparam int IDX_W   = $clog2(N_REQ);
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d, rr_ptr_q, rr_ptr_d;
  req_t              req_q, req_d, sel_req;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LINE_W-1:0] line_buf_q, line_buf_d, merged;
  logic [N_REQ-1:0]  rsp_done_q, rsp_done_d, req_eff;
  logic [LINE_W-1:0] rsp_rdat_q, rsp_rdat_d;
  logic              busy_q, busy_d;
  logic [WORD_W-1:0] mem_addr_sel_q, mem_addr_sel_d, sel_addr;
  logic              mem_en_q, mem_en_d, mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [LINE_W-1:0] mem_wdat_q, mem_wdat_d;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;

  // A requester still sees its own rsp_done on this edge and drops req_valid
  // on it; masking keeps that stale request from being re-granted.
  assign req_eff = bus.req_valid & ~rsp_done_q;

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req     (req_eff),
    .ptr     (rr_ptr_q),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    rr_ptr_d       = rr_ptr_q;
    req_d          = req_q;
    cnt_d          = cnt_q;
    line_buf_d     = line_buf_q;
    rsp_done_d     = '0;
    rsp_rdat_d     = rsp_rdat_q;
    mem_addr_sel_d = mem_addr_sel_q;
    mem_en_d       = mem_en_q;
    mem_re_d       = mem_re_q;
    mem_we_d       = mem_we_q;
    mem_wdat_d     = mem_wdat_q;
    merged         = merge_word(line_buf_q, req_q.wdat, req_q.lane);
    sel_req        = '0;
    sel_addr       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IDX_W'(i) == gnt_idx) begin
        sel_addr     = bus.req_addr[i*WORD_W +: WORD_W];
        sel_req.we   = bus.req_we[i];
        sel_req.wdat = bus.req_wdat[i*WORD_W +: WORD_W];
      end
    end
    sel_req.lane = lane_of(sel_addr);

    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          gnt_d          = gnt_idx;
          req_d          = sel_req;
          mem_addr_sel_d = line_addr(sel_addr);
          mem_en_d       = 1'b1;
          mem_re_d       = 1'b1;
          mem_we_d       = 1'b0;
          cnt_d          = '0;
          rr_ptr_d       = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
          state_d        = RD;
        end
      end
      RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          line_buf_d = bus.mem_rdat;
          mem_re_d   = 1'b0;
          if (req_q.we) begin
            state_d = MERGE;
          end else begin
            mem_en_d = 1'b0;
            state_d  = DONE;
          end
        end
      end
      MERGE: begin
        line_buf_d = merged;
        mem_wdat_d = merged;
        mem_we_d   = 1'b1;
        cnt_d      = '0;
        state_d    = WR;
      end
      WR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WR_LAT - 1)) begin
          mem_we_d = 1'b0;
          mem_en_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        for (int i = 0; i < N_REQ; i++) rsp_done_d[i] = (IDX_W'(i) == gnt_q);
        rsp_rdat_d = line_buf_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q        <= IDLE;
      gnt_q          <= '0;
      rr_ptr_q       <= '0;
      req_q          <= '0;
      cnt_q          <= '0;
      line_buf_q     <= '0;
      rsp_done_q     <= '0;
      rsp_rdat_q     <= '0;
      busy_q         <= 1'b0;
      mem_addr_sel_q <= '0;
      mem_en_q       <= 1'b0;
      mem_re_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_wdat_q     <= '0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      rr_ptr_q       <= rr_ptr_d;
      req_q          <= req_d;
      cnt_q          <= cnt_d;
      line_buf_q     <= line_buf_d;
      rsp_done_q     <= rsp_done_d;
      rsp_rdat_q     <= rsp_rdat_d;
      busy_q         <= busy_d;
      mem_addr_sel_q <= mem_addr_sel_d;
      mem_en_q       <= mem_en_d;
      mem_re_q       <= mem_re_d;
      mem_we_q       <= mem_we_d;
      mem_wdat_q     <= mem_wdat_d;
    end
  end

  assign bus.rsp_done     = rsp_done_q;
  assign bus.rsp_rdat     = rsp_rdat_q;
  assign bus.busy         = busy_q;
  assign bus.mem_addr_sel = mem_addr_sel_q;
  assign bus.mem_en       = mem_en_q;
  assign bus.mem_re       = mem_re_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_wdat     = mem_wdat_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of single transactions plus
// directed sequences for fairness, mid-transaction reset and early req drop.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int N_REQ  = 4;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 2;
  localparam logic [LINE_W-1:0] GARBAGE = {4{32'h5A5A_5A5A}};

  typedef struct {
    int                idx;
    logic              we;
    logic [31:0]       addr;
    logic [31:0]       wdat;
    logic [LINE_W-1:0] line;
    logic [31:0]       exp_sel;
    logic [LINE_W-1:0] exp_rdat;
    logic [LINE_W-1:0] exp_wdat;
    int                exp_lat;
  } vec_t;

  logic mclk = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   re_age = 0;

  logic [LINE_W-1:0] mem_line = '0;
  int   re_cyc = 0, we_cyc = 0, overlap = 0, en_err = 0, wdat_unstable = 0;
  logic prev_we = 1'b0;
  logic [LINE_W-1:0] burst_wdat = '0;

  vec_t vecs[5];

  mem_arbiter_if #(.N_REQ(N_REQ)) bus();

  mem_arbiter #(.N_REQ(N_REQ), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .mclk (mclk),
    .rst  (rst),
    .bus  (bus)
  );

  always #5 mclk = ~mclk;

  // Memory model: read data is valid only RD_LAT edges into a mem_re burst.
  always @(posedge mclk) begin
    cyc    <= cyc + 1;
    re_age <= bus.mem_re ? re_age + 1 : 0;
  end
  assign bus.mem_rdat = (bus.mem_re && re_age >= RD_LAT - 1) ? mem_line : GARBAGE;

  always @(negedge mclk) begin
    if (bus.mem_re) re_cyc++;
    if (bus.mem_we) begin
      we_cyc++;
      if (!prev_we) burst_wdat = bus.mem_wdat;
      else if (bus.mem_wdat !== burst_wdat) wdat_unstable++;
    end
    if (bus.mem_re && bus.mem_we) overlap++;
    if ((bus.mem_re || bus.mem_we) && !bus.mem_en) en_err++;
    prev_we = bus.mem_we;
  end

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(output logic [N_REQ-1:0] d);
    d = '0;
    for (int n = 0; n < 40; n++) begin
      @(posedge mclk); #1;
      if (bus.rsp_done != '0) begin
        d = bus.rsp_done;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge mclk); #1;
    rst = 1'b0;
  endtask

  task automatic set_req(input int idx, input logic we, input logic [31:0] addr, input logic [31:0] wdat);
    bus.req_we[idx]              = we;
    bus.req_addr[idx*32 +: 32]   = addr;
    bus.req_wdat[idx*32 +: 32]   = wdat;
    bus.req_valid[idx]           = 1'b1;
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int re0, we0, g0;
    logic [N_REQ-1:0] d, exp_d;
    re0   = re_cyc;
    we0   = we_cyc;
    exp_d = '0;
    exp_d[v.idx] = 1'b1;
    mem_line = v.line;
    set_req(v.idx, v.we, v.addr, v.wdat);
    @(posedge mclk); #1;
    g0 = cyc;
    check({tag, "_grant_busy"}, 128'(bus.busy), 128'(1));
    check({tag, "_addr_sel"}, 128'(bus.mem_addr_sel), 128'(v.exp_sel));
    check({tag, "_grant_en_re_we"}, 128'({bus.mem_en, bus.mem_re, bus.mem_we}), 128'(3'b110));
    wait_done(d);
    check({tag, "_rsp_done"}, 128'(d), 128'(exp_d));
    check({tag, "_latency"}, 128'(cyc - g0), 128'(v.exp_lat));
    check({tag, "_rsp_rdat"}, bus.rsp_rdat, v.exp_rdat);
    check({tag, "_re_cycles"}, 128'(re_cyc - re0), 128'(RD_LAT));
    check({tag, "_we_cycles"}, 128'(we_cyc - we0), v.we ? 128'(WR_LAT) : 128'(0));
    if (v.we) check({tag, "_mem_wdat"}, burst_wdat, v.exp_wdat);
    check({tag, "_en_off_at_done"}, 128'(bus.mem_en), 128'(0));
    @(posedge mclk); #1;
    bus.req_valid[v.idx] = 1'b0;
    check({tag, "_done_one_cycle"}, 128'(bus.rsp_done), 128'(0));
    check({tag, "_rdat_held"}, bus.rsp_rdat, v.exp_rdat);
    check({tag, "_idle_after"}, 128'(bus.busy), 128'(0));
  endtask

  initial begin
    logic [N_REQ-1:0] d;
    int pulses;
    int starve_seq[4];

    vecs[0] = '{idx: 0, we: 1'b0, addr: 32'h0000_0040, wdat: 32'h0,
                line: {4{32'hAAAA_AAAA}}, exp_sel: 32'h0000_0040,
                exp_rdat: {4{32'hAAAA_AAAA}}, exp_wdat: '0, exp_lat: 3};
    vecs[1] = '{idx: 1, we: 1'b1, addr: 32'h0000_0048, wdat: 32'hDEAD_BEEF,
                line: '0, exp_sel: 32'h0000_0040,
                exp_rdat: 128'h00000000_DEADBEEF_00000000_00000000,
                exp_wdat: 128'h00000000_DEADBEEF_00000000_00000000, exp_lat: 6};
    vecs[2] = '{idx: 3, we: 1'b1, addr: 32'h1234_567C, wdat: 32'h0102_0304,
                line: 128'h11111111_22222222_33333333_44444444, exp_sel: 32'h1234_5670,
                exp_rdat: 128'h01020304_22222222_33333333_44444444,
                exp_wdat: 128'h01020304_22222222_33333333_44444444, exp_lat: 6};
    vecs[3] = '{idx: 2, we: 1'b0, addr: 32'hFFFF_FFF4, wdat: 32'h1111_1111,
                line: 128'h0123456789ABCDEF_FEDCBA9876543210, exp_sel: 32'hFFFF_FFF0,
                exp_rdat: 128'h0123456789ABCDEF_FEDCBA9876543210, exp_wdat: '0, exp_lat: 3};
    vecs[4] = '{idx: 0, we: 1'b1, addr: 32'h0000_0104, wdat: 32'hCAFE_F00D,
                line: {4{32'hFFFF_FFFF}}, exp_sel: 32'h0000_0100,
                exp_rdat: 128'hFFFFFFFF_FFFFFFFF_CAFEF00D_FFFFFFFF,
                exp_wdat: 128'hFFFFFFFF_FFFFFFFF_CAFEF00D_FFFFFFFF, exp_lat: 6};

    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdat  = '0;

    repeat (2) @(posedge mclk);
    #1;
    check("rst_rsp_done", 128'(bus.rsp_done), 128'(0));
    check("rst_rsp_rdat", bus.rsp_rdat, 128'(0));
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_addr_sel", 128'(bus.mem_addr_sel), 128'(0));
    check("rst_en_re_we", 128'({bus.mem_en, bus.mem_re, bus.mem_we}), 128'(0));
    check("rst_wdat", bus.mem_wdat, 128'(0));
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // All four at once from rr_ptr 0: grants 0,1,2,3, then the pointer wraps.
    do_reset();
    mem_line = {4{32'h1357_9BDF}};
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b0, 32'h0000_0200 + 32'(i * 16), 32'h0);
    for (int k = 0; k < N_REQ; k++) begin
      wait_done(d);
      check($sformatf("all4_grant%0d", k), 128'(d), 128'(4'b0001 << k));
      @(posedge mclk); #1;
      bus.req_valid[k] = 1'b0;
    end
    bus.req_valid = 4'b1001;
    wait_done(d);
    check("wrap_first_req0", 128'(d), 128'(4'b0001));
    @(posedge mclk); #1;
    bus.req_valid[0] = 1'b0;
    wait_done(d);
    check("wrap_then_req3", 128'(d), 128'(4'b1000));
    @(posedge mclk); #1;
    bus.req_valid[3] = 1'b0;

    // req2 and req3 never drop: grants must alternate.
    do_reset();
    starve_seq = '{2, 3, 2, 3};
    set_req(2, 1'b0, 32'h0000_0300, 32'h0);
    set_req(3, 1'b0, 32'h0000_0310, 32'h0);
    for (int k = 0; k < 4; k++) begin
      wait_done(d);
      check($sformatf("alt_grant%0d", k), 128'(d), 128'(4'b0001 << starve_seq[k]));
    end
    bus.req_valid = '0;
    repeat (8) @(posedge mclk);
    #1;
    check("alt_idle", 128'(bus.busy), 128'(0));

    // Reset while in WR abandons the write without a response.
    set_req(1, 1'b1, 32'h0000_0048, 32'h1234_5678);
    mem_line = '0;
    @(posedge mclk); #1;
    repeat (3) begin
      @(posedge mclk); #1;
    end
    check("wr_before_rst", 128'({bus.mem_en, bus.mem_re, bus.mem_we}), 128'(3'b101));
    rst = 1'b1;
    @(posedge mclk); #1;
    rst = 1'b0;
    bus.req_valid[1] = 1'b0;
    check("rst_wr_en_re_we", 128'({bus.mem_en, bus.mem_re, bus.mem_we}), 128'(0));
    check("rst_wr_busy", 128'(bus.busy), 128'(0));
    pulses = 0;
    for (int n = 0; n < 10; n++) begin
      if (bus.rsp_done != '0) pulses++;
      @(posedge mclk); #1;
    end
    check("rst_wr_no_done", 128'(pulses), 128'(0));
    run_txn(vecs[0], "post_rst");

    // req0 drops valid one cycle after grant; the latched copy completes.
    mem_line = 128'hFEEDFACE_0BADF00D_8BADF00D_C0FFEE00;
    set_req(0, 1'b0, 32'h0000_0A00, 32'h0);
    @(posedge mclk); #1;
    pulses = cyc;
    @(posedge mclk); #1;
    bus.req_valid[0] = 1'b0;
    wait_done(d);
    check("drop_rsp_done", 128'(d), 128'(4'b0001));
    check("drop_latency", 128'(cyc - pulses), 128'(3));
    check("drop_rsp_rdat", bus.rsp_rdat, 128'hFEEDFACE_0BADF00D_8BADF00D_C0FFEE00);

    repeat (2) @(posedge mclk);
    #1;
    check("never_re_and_we", 128'(overlap), 128'(0));
    check("en_covers_re_we", 128'(en_err), 128'(0));
    check("wdat_stable_in_wr", 128'(wdat_unstable), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
